ce_ls_seq: RTL and testbench
============================

# ce_ls_seq

Sequencer that drives the per-subcarrier read stream feeding the CE least-square stage. On one start pulse it walks every (rx antenna, UE) pair of a job and issues one Avalon-ST-style command frame of `fftpts` sample addresses per pair. Each frame carries sop/eop and antenna/UE tags, so the LS datapath selects the right RS coefficients and the downstream DCT sees clean frame boundaries. It sits between the antenna sample buffers and the LS multiplier, and absorbs backpressure from it.

## Interface
- NANT_MAX, 8: maximum rx antennas per job
- NUE_MAX, 4: maximum UEs per job
- GAP, 2: idle cycles inserted between consecutive frames (0 allowed)
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  job start pulse; honoured only in IDLE
- abort  in  1  synchronous job abort
- cfg_nant  in  4  antennas in job, 1..NANT_MAX
- cfg_nue  in  3  UEs in job, 1..NUE_MAX
- fftpts_in  in  12  frame length, power of two, 2..2048
- cmd_valid  out  1  command valid
- cmd_ready  in  1  LS stage ready
- cmd_addr  out  12  sample index within antenna buffer
- cmd_ant  out  4  antenna index
- cmd_ue  out  3  UE index (selects RS coefficients)
- cmd_sop / cmd_eop  out  1 each  first / last sample of frame
- cmd_last  out  1  eop of final frame of job
- busy  out  1  high from RUN entry until DONE exit
- done  out  1  one-cycle pulse, job completed
- cfg_err  out  1  one-cycle pulse, start rejected

## Operation
- States: IDLE, RUN, GAP, DONE.
- IDLE + start: latch cfg_nant, cfg_nue, fftpts_in and validate them.
  - Invalid (any of: nant=0, nant>NANT_MAX, nue=0, nue>NUE_MAX, fftpts not a power of two, fftpts<2): cfg_err pulses, state stays IDLE.
  - Valid: go to RUN with addr=0, ant=0, ue=0.
- RUN: cmd_valid=1. A transfer happens when cmd_valid&&cmd_ready.
  - Each transfer increments addr.
  - On the eop transfer (addr=fftpts-1): addr←0 and ue increments; when ue wraps at nue-1, ant increments.
- Frame order: antenna outer, UE inner. Each antenna buffer is replayed nue times.
- After an eop transfer:
  - last frame → DONE;
  - otherwise → GAP if GAP>0, else stay in RUN with sop on the next beat.
- GAP: cmd_valid=0 for exactly GAP cycles, then RUN.
- DONE: done=1 for one cycle, then IDLE.
- abort (any state except IDLE): next state is IDLE, cmd_valid=0 at the next edge, no done pulse, latched config discarded. abort has priority over every other transition.
- start is ignored outside IDLE. start and abort in the same IDLE cycle: start is honoured.
- cmd_sop = (addr==0). cmd_eop = (addr==fftpts-1). cmd_last = cmd_eop && final ant && final ue.
- Counter widths: addr 12, ant 4, ue 3. No wrap beyond latched limits.

## Timing
- Reset values: every output is 0. State = IDLE, all counters 0.
- All outputs are registered.
- start in cycle T:
  - valid config: first beat (sop, addr 0, ant 0, ue 0) presented in cycle T+1;
  - invalid config: cfg_err high in cycle T+1.
- While cmd_valid && !cmd_ready, all cmd_* outputs hold stable.
- cmd_ready is a don't-care when cmd_valid=0.
- With cmd_ready held high: job length = nant·nue·fftpts beats + (nant·nue−1)·GAP gap cycles. done rises the cycle after the cmd_last transfer.
- busy falls the same edge done falls.
- The stall/hold rule also applies across the eop→GAP boundary: the eop beat holds until accepted.
- Reset asserted mid-job: outputs go to 0 asynchronously. After release the block is in IDLE awaiting start.

## Structure
- Shared package `ce_pkg`:
  - state enum (IDLE/RUN/GAP/DONE);
  - NANT_MAX/NUE_MAX defaults and their counter widths;
  - `is_pow2` function (12-bit) for config validation, reused by other CE blocks that take fftpts_in.
- No sub-module: the nested addr/ue/ant counters and FSM stay in one module, about 200 lines.

## Test plan
- nant=2, nue=2, fftpts=8, GAP=2, ready=1 → 32 beats. Ant/ue order (0,0),(0,1),(1,0),(1,1). Two-cycle valid gaps after beats 8, 16 and 24. cmd_last on beat 32. done one cycle later.
- fftpts=12, or nant=0, or nue=5 → cfg_err pulse in cycle T+1, busy stays 0, no cmd_valid.
- Random cmd_ready (~50%) over nant=3, nue=1, fftpts=16 → every held beat stable. Exactly 48 accepted beats with contiguous addrs 0..15 per frame.
- abort at beat 5 of frame 2 → cmd_valid=0 next cycle, no done. A new start runs a full job from ant 0, ue 0.
- GAP=0, nant=1, nue=3, fftpts=2 → 6 consecutive beats, sop on beats 1, 3, 5. start re-asserted mid-job is ignored.
- rst_n pulled low mid-frame → all outputs 0 immediately. After release, start produces a normal first beat in T+1.

Source files
------------

// File: rtl/ce_pkg.sv
// Shared channel-estimation definitions: sequencer states, job-size defaults
// and the fftpts power-of-two check used by every CE block that takes fftpts_in.
package ce_pkg;

  localparam int NANT_MAX_DEF = 8;
  localparam int NUE_MAX_DEF  = 4;

  localparam int ANT_W  = 4;
  localparam int UE_W   = 3;
  localparam int ADDR_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_DONE
  } ce_state_e;

  function automatic logic is_pow2(input logic [11:0] x);
    return (x != 12'd0) && ((x & (x - 12'd1)) == 12'd0);
  endfunction

endpackage

// File: rtl/ce_ls_seq.sv
// LS-stage read sequencer: one command frame of fftpts sample addresses per
// (antenna, UE) pair, antenna outer / UE inner, with GAP idle cycles between frames.
module ce_ls_seq
  import ce_pkg::*;
#(
  parameter int NANT_MAX = NANT_MAX_DEF,
  parameter int NUE_MAX  = NUE_MAX_DEF,
  parameter int GAP      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ANT_W-1:0]  cfg_nant,
  input  logic [UE_W-1:0]   cfg_nue,
  input  logic [ADDR_W-1:0] fftpts_in,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [ANT_W-1:0]  cmd_ant,
  output logic [UE_W-1:0]   cmd_ue,
  output logic              cmd_sop,
  output logic              cmd_eop,
  output logic              cmd_last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  ce_state_e         state;
  logic [ANT_W-1:0]  lat_nant;
  logic [UE_W-1:0]   lat_nue;
  logic [ADDR_W-1:0] lat_fft;
  logic [GAP_W-1:0]  gap_cnt;

  logic              cfg_ok;
  logic              xfer;
  logic              last_ant;
  logic              last_ue;
  logic [ADDR_W-1:0] addr_nxt;
  logic              eop_nxt;

  assign cfg_ok = (cfg_nant != '0) && (int'(cfg_nant) <= NANT_MAX) &&
                  (cfg_nue != '0) && (int'(cfg_nue) <= NUE_MAX) &&
                  is_pow2(fftpts_in) && (fftpts_in >= 12'd2);

  assign xfer     = cmd_valid && cmd_ready;
  assign last_ant = (cmd_ant == lat_nant - 4'd1);
  assign last_ue  = (cmd_ue == lat_nue - 3'd1);
  assign addr_nxt = cmd_addr + 12'd1;
  assign eop_nxt  = (addr_nxt == lat_fft - 12'd1);

  // The cmd_addr/cmd_ant/cmd_ue registers double as the walk counters, so the
  // presented beat and the sequencer position can never disagree during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      lat_nant  <= '0;
      lat_nue   <= '0;
      lat_fft   <= '0;
      gap_cnt   <= '0;
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_ant   <= '0;
      cmd_ue    <= '0;
      cmd_sop   <= 1'b0;
      cmd_eop   <= 1'b0;
      cmd_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else if (abort && state != ST_IDLE) begin
      state     <= ST_IDLE;
      lat_nant  <= '0;
      lat_nue   <= '0;
      lat_fft   <= '0;
      gap_cnt   <= '0;
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_ant   <= '0;
      cmd_ue    <= '0;
      cmd_sop   <= 1'b0;
      cmd_eop   <= 1'b0;
      cmd_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cfg_err <= 1'b0;
          done    <= 1'b0;
          if (start) begin
            if (cfg_ok) begin
              lat_nant  <= cfg_nant;
              lat_nue   <= cfg_nue;
              lat_fft   <= fftpts_in;
              state     <= ST_RUN;
              cmd_valid <= 1'b1;
              cmd_addr  <= '0;
              cmd_ant   <= '0;
              cmd_ue    <= '0;
              cmd_sop   <= 1'b1;
              cmd_eop   <= 1'b0;
              cmd_last  <= 1'b0;
              busy      <= 1'b1;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (xfer) begin
            if (cmd_last) begin
              state     <= ST_DONE;
              cmd_valid <= 1'b0;
              cmd_addr  <= '0;
              cmd_ant   <= '0;
              cmd_ue    <= '0;
              cmd_sop   <= 1'b0;
              cmd_eop   <= 1'b0;
              cmd_last  <= 1'b0;
              done      <= 1'b1;
            end else if (cmd_eop) begin
              cmd_addr <= '0;
              cmd_sop  <= 1'b1;
              cmd_eop  <= 1'b0;
              cmd_last <= 1'b0;
              if (last_ue) begin
                cmd_ue  <= '0;
                cmd_ant <= cmd_ant + 4'd1;
              end else begin
                cmd_ue <= cmd_ue + 3'd1;
              end
              if (GAP == 0) begin
                cmd_valid <= 1'b1;
              end else begin
                state     <= ST_GAP;
                cmd_valid <= 1'b0;
                gap_cnt   <= GAP_W'(GAP - 1);
              end
            end else begin
              cmd_addr <= addr_nxt;
              cmd_sop  <= 1'b0;
              cmd_eop  <= eop_nxt;
              cmd_last <= eop_nxt && last_ant && last_ue;
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == '0) begin
            state     <= ST_RUN;
            cmd_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        ST_DONE: begin
          state    <= ST_IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          lat_nant <= '0;
          lat_nue  <= '0;
          lat_fft  <= '0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ce_ls_seq.sv
// Bench for ce_ls_seq: a frame-list model plus a per-cycle checker on the
// GAP=2 instance, and literal sequences on a GAP=0 instance.
module tb_ce_ls_seq;

  localparam int GAP_T = 2;

  typedef struct packed {
    logic [11:0] addr;
    logic [3:0]  ant;
    logic [2:0]  ue;
    logic        sop;
    logic        eop;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, ready = 1'b1;
  logic [3:0]  cfg_nant = '0;
  logic [2:0]  cfg_nue = '0;
  logic [11:0] fftpts = '0;
  logic        cmd_valid, cmd_sop, cmd_eop, cmd_last, busy, done, cfg_err;
  logic [11:0] cmd_addr;
  logic [3:0]  cmd_ant;
  logic [2:0]  cmd_ue;

  logic        start0 = 1'b0;
  logic        valid0, sop0, eop0, last0, busy0, done0, err0;
  logic [11:0] addr0;
  logic [3:0]  ant0;
  logic [2:0]  ue0;

  int    n_vec = 0;
  int    n_err = 0;
  int    accepted = 0;
  bit    chk_en = 1'b0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  ce_ls_seq #(.NANT_MAX(8), .NUE_MAX(4), .GAP(GAP_T)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_nant(cfg_nant), .cfg_nue(cfg_nue), .fftpts_in(fftpts),
    .cmd_valid(cmd_valid), .cmd_ready(ready), .cmd_addr(cmd_addr),
    .cmd_ant(cmd_ant), .cmd_ue(cmd_ue), .cmd_sop(cmd_sop), .cmd_eop(cmd_eop),
    .cmd_last(cmd_last), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  ce_ls_seq #(.NANT_MAX(8), .NUE_MAX(4), .GAP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(1'b0),
    .cfg_nant(4'd1), .cfg_nue(3'd3), .fftpts_in(12'd2),
    .cmd_valid(valid0), .cmd_ready(1'b1), .cmd_addr(addr0),
    .cmd_ant(ant0), .cmd_ue(ue0), .cmd_sop(sop0), .cmd_eop(eop0),
    .cmd_last(last0), .busy(busy0), .done(done0), .cfg_err(err0)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected job: every antenna buffer replayed once per UE, addresses 0..fft-1.
  task automatic buildJob(input int nant, input int nue, input int fft);
    beat_t b;
    for (int a = 0; a < nant; a++)
      for (int u = 0; u < nue; u++)
        for (int i = 0; i < fft; i++) begin
          b.addr = 12'(i);
          b.ant  = 4'(a);
          b.ue   = 3'(u);
          b.sop  = (i == 0);
          b.eop  = (i == fft - 1);
          b.last = (i == fft - 1) && (a == nant - 1) && (u == nue - 1);
          exp_q.push_back(b);
        end
  endtask

  task automatic applyStimulus(input logic [3:0] nant, input logic [2:0] nue, input logic [11:0] fft);
    cfg_nant = nant;
    cfg_nue  = nue;
    fftpts   = fft;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic waitDone(input int budget, input bit rnd, output int n);
    n = 0;
    while (!done && n < budget) begin
      if (rnd) ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    checkOutput("done_seen", int'(done), 1);
    ready = 1'b1;
  endtask

  // Per-cycle checker: beat order, stall hold, gap length and done/busy timing.
  bit    gap_pending, prev_stall, exp_done, prev_done;
  int    gap_cnt;
  beat_t prev_beat;

  always @(negedge clk) begin
    beat_t cur;
    bit    done_nxt;
    cur = {cmd_addr, cmd_ant, cmd_ue, cmd_sop, cmd_eop, cmd_last};
    if (!chk_en) begin
      gap_pending = 0;
      prev_stall  = 0;
      exp_done    = 0;
      prev_done   = 0;
    end else begin
      done_nxt = 0;
      checkOutput("done_timing", int'(done), int'(exp_done));
      if (prev_done) checkOutput("busy_after_done", int'(busy), 0);
      if (prev_stall) begin
        checkOutput("hold_valid", int'(cmd_valid), 1);
        checkOutput("hold_beat", int'(cur), int'(prev_beat));
      end
      if (gap_pending) begin
        if (!cmd_valid) gap_cnt++;
        else begin
          checkOutput("gap_len", gap_cnt, GAP_T);
          gap_pending = 0;
        end
      end
      if (cmd_valid) begin
        if (exp_q.size() == 0) checkOutput("unexpected_valid", 1, 0);
        else begin
          checkOutput("beat", int'(cur), int'(exp_q[0]));
          if (ready) begin
            accepted++;
            if (exp_q[0].last) done_nxt = 1;
            else if (exp_q[0].eop) begin
              gap_pending = 1;
              gap_cnt = 0;
            end
            void'(exp_q.pop_front());
          end
        end
      end
      prev_stall = cmd_valid && !ready;
      prev_beat  = cur;
      prev_done  = done;
      exp_done   = done_nxt;
    end
  end

  initial begin
    int n;
    int acc0;
    bit found;
    logic [5:0] sop_pat;
    int ue_pat[6];
    sop_pat = 6'b010101;
    ue_pat  = '{0, 0, 1, 1, 2, 2};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs",
      int'({cmd_valid, cmd_addr, cmd_ant, cmd_ue, cmd_sop, cmd_eop, cmd_last, busy, done, cfg_err}), 0);
    checkOutput("reset_outputs0", int'({valid0, busy0, done0, err0, sop0}), 0);
    rst_n = 1'b1;
    tick();
    chk_en = 1'b1;

    // 2 ant x 2 ue x 8 pts, ready held: 32 beats + 3 gaps of 2
    buildJob(2, 2, 8);
    acc0 = accepted;
    applyStimulus(4'd2, 3'd2, 12'd8);
    checkOutput("first_beat", int'({cmd_valid, cmd_sop, cmd_eop, cmd_last, cmd_addr, cmd_ant, cmd_ue}), 'h600000);
    checkOutput("busy_run", int'(busy), 1);
    waitDone(200, 1'b0, n);
    checkOutput("job_cycles", n, 38);
    checkOutput("job_beats", accepted - acc0, 32);
    checkOutput("job_queue_empty", exp_q.size(), 0);
    tick();
    tick();

    // rejected configurations
    applyStimulus(4'd2, 3'd2, 12'd12);
    checkOutput("err_fft12", int'({cfg_err, busy, cmd_valid}), 'b100);
    tick();
    checkOutput("err_fft12_clear", int'({cfg_err, busy, cmd_valid}), 0);
    applyStimulus(4'd0, 3'd2, 12'd8);
    checkOutput("err_nant0", int'({cfg_err, busy, cmd_valid}), 'b100);
    tick();
    applyStimulus(4'd2, 3'd5, 12'd8);
    checkOutput("err_nue5", int'({cfg_err, busy, cmd_valid}), 'b100);
    tick();
    checkOutput("err_nue5_clear", int'({cfg_err, busy, cmd_valid}), 0);

    // random backpressure, 3 ant x 1 ue x 16 pts
    buildJob(3, 1, 16);
    acc0 = accepted;
    applyStimulus(4'd3, 3'd1, 12'd16);
    waitDone(2000, 1'b1, n);
    checkOutput("stall_beats", accepted - acc0, 48);
    checkOutput("stall_queue_empty", exp_q.size(), 0);
    tick();
    tick();

    // abort on beat 5 of frame 2 (ant 0, ue 1, addr 4)
    buildJob(2, 2, 8);
    applyStimulus(4'd2, 3'd2, 12'd8);
    n = 0;
    while (!(cmd_valid && cmd_ue == 3'd1 && cmd_addr == 12'd4) && n < 100) begin
      tick();
      n++;
    end
    found = cmd_valid && cmd_ue == 3'd1 && cmd_addr == 12'd4;
    checkOutput("abort_point_found", int'(found), 1);
    abort  = 1'b1;
    chk_en = 1'b0;
    tick();
    abort = 1'b0;
    checkOutput("abort_outputs", int'({cmd_valid, busy, done}), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("abort_no_done", int'({cmd_valid, done}), 0);
    end
    exp_q.delete();
    chk_en = 1'b1;

    // restart with start and abort together in IDLE: start wins
    buildJob(2, 2, 8);
    acc0 = accepted;
    abort = 1'b1;
    applyStimulus(4'd2, 3'd2, 12'd8);
    abort = 1'b0;
    checkOutput("restart_first_beat", int'({cmd_valid, cmd_sop, cmd_eop, cmd_last, cmd_addr, cmd_ant, cmd_ue}), 'h600000);
    waitDone(200, 1'b0, n);
    checkOutput("restart_cycles", n, 38);
    checkOutput("restart_beats", accepted - acc0, 32);
    tick();
    tick();

    // GAP=0 instance: 1 ant x 3 ue x 2 pts, start re-pulsed mid-job
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checkOutput("g0_valid", int'(valid0), 1);
      checkOutput("g0_sop", int'(sop0), int'(sop_pat[i]));
      checkOutput("g0_addr", int'(addr0), i % 2);
      checkOutput("g0_ue", int'(ue0), ue_pat[i]);
      checkOutput("g0_last", int'(last0), (i == 5) ? 1 : 0);
      start0 = (i == 2);
      tick();
    end
    start0 = 1'b0;
    checkOutput("g0_done", int'({done0, busy0, valid0}), 'b110);
    tick();
    checkOutput("g0_idle", int'({done0, busy0, valid0}), 0);
    tick();
    checkOutput("g0_restart_ignored", int'(valid0), 0);

    // asynchronous reset mid-frame
    chk_en = 1'b0;
    applyStimulus(4'd2, 3'd2, 12'd8);
    n = 0;
    while (cmd_addr != 12'd3 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("rst_point_found", int'(cmd_addr), 3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_outputs",
      int'({cmd_valid, cmd_addr, cmd_ant, cmd_ue, cmd_sop, cmd_eop, cmd_last, busy, done, cfg_err}), 0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.delete();
    chk_en = 1'b1;
    buildJob(1, 1, 2);
    acc0 = accepted;
    applyStimulus(4'd1, 3'd1, 12'd2);
    checkOutput("rst_first_beat", int'({cmd_valid, cmd_sop, cmd_eop, cmd_last, cmd_addr, cmd_ant, cmd_ue}), 'h600000);
    waitDone(20, 1'b0, n);
    checkOutput("rst_job_cycles", n, 2);
    checkOutput("rst_job_beats", accepted - acc0, 2);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
